// File: rtl/trap_entry_seq_pkg.sv
// Shared definitions for the trap entry sequencer: CSR addresses, states and
// privilege encoding.
package trap_entry_seq_pkg;

   localparam logic [11:0] MEPC   = 12'h341;
   localparam logic [11:0] MCAUSE = 12'h342;
   localparam logic [11:0] MTVAL  = 12'h343;
   localparam logic [11:0] SEPC   = 12'h141;
   localparam logic [11:0] SCAUSE = 12'h142;
   localparam logic [11:0] STVAL  = 12'h143;

   // Bit positions inside the one-hot privilege vector
   localparam int unsigned PRIV_U = 0;
   localparam int unsigned PRIV_S = 1;
   localparam int unsigned PRIV_M = 3;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      W_EPC,
      W_CAUSE,
      W_TVAL,
      COMMIT,
      REDIRECT
   } state_t;

   function automatic logic [11:0] csr_pick(input logic to_s,
                                            input logic [11:0] m_addr,
                                            input logic [11:0] s_addr);
      return to_s ? s_addr : m_addr;
   endfunction

endpackage

// File: rtl/trap_entry_seq_vec_calc.sv
// Trap vector target: direct base, or base + 4*code for vectored interrupts.
module trap_vec_calc #(
   parameter int unsigned XLEN = 64
) (
   input  logic [XLEN-1:0] tvec,
   input  logic            is_int,
   input  logic [5:0]      code,
   output logic [XLEN-1:0] pc
);

   logic [XLEN-1:0] base;
   logic [XLEN-1:0] offset;

   always_comb begin
      base   = {tvec[XLEN-1:2], 2'b00};
      offset = '0;
      if (tvec[1:0] == 2'b01 && is_int)
         offset = {{(XLEN-8){1'b0}}, code, 2'b00};
      pc = base + offset;
   end

endmodule

// File: rtl/trap_entry_seq.sv
// Trap entry sequencer: arbitrate exception vs interrupt, drain the pipe,
// write xEPC/xCAUSE/xTVAL, commit status and redirect fetch.
module trap_entry_seq
   import trap_entry_seq_pkg::*;
#(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned DRAIN_MAX = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            int_req,
   input  logic            int_target_s,
   input  logic [XLEN-1:0] int_cause,
   input  logic            exc_req,
   input  logic            exc_to_s,
   input  logic [XLEN-1:0] exc_cause,
   input  logic [XLEN-1:0] exc_tval,
   input  logic [XLEN-1:0] epc_in,
   input  logic            pipe_idle,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] stvec,
   input  logic [3:0]      priv,
   output logic            hold_pipe,
   output logic            trap_ack,
   output logic            csr_we,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            status_commit,
   output logic            commit_to_s,
   output logic [3:0]      prev_priv,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            busy
);

   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_MAX - 1);

   state_t          state;
   logic [XLEN-1:0] cause_q;
   logic [XLEN-1:0] tval_q;
   logic [XLEN-1:0] epc_q;
   logic            to_s_q;
   logic [3:0]      priv_q;
   logic [3:0]      drain_cnt;
   logic [XLEN-1:0] tvec;
   logic [XLEN-1:0] vec_pc;

   assign tvec = to_s_q ? stvec : mtvec;

   trap_vec_calc #(.XLEN(XLEN)) u_vec_calc (
      .tvec   (tvec),
      .is_int (cause_q[XLEN-1]),
      .code   (cause_q[5:0]),
      .pc     (vec_pc)
   );

   // Outputs are registered alongside the transition into the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cause_q        <= '0;
         tval_q         <= '0;
         epc_q          <= '0;
         to_s_q         <= 1'b0;
         priv_q         <= '0;
         drain_cnt      <= '0;
         hold_pipe      <= 1'b0;
         busy           <= 1'b0;
         trap_ack       <= 1'b0;
         csr_we         <= 1'b0;
         csr_addr       <= '0;
         csr_wdata      <= '0;
         status_commit  <= 1'b0;
         commit_to_s    <= 1'b0;
         prev_priv      <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         trap_ack       <= 1'b0;
         csr_we         <= 1'b0;
         csr_addr       <= '0;
         csr_wdata      <= '0;
         status_commit  <= 1'b0;
         commit_to_s    <= 1'b0;
         prev_priv      <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         case (state)
            IDLE: begin
               if (exc_req || int_req) begin
                  cause_q   <= exc_req ? exc_cause : int_cause;
                  tval_q    <= exc_req ? exc_tval : '0;
                  to_s_q    <= exc_req ? exc_to_s : int_target_s;
                  epc_q     <= epc_in;
                  priv_q    <= priv;
                  drain_cnt <= '0;
                  trap_ack  <= 1'b1;
                  hold_pipe <= 1'b1;
                  busy      <= 1'b1;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (pipe_idle || drain_cnt == DRAIN_LAST) begin
                  csr_we    <= 1'b1;
                  csr_addr  <= csr_pick(to_s_q, MEPC, SEPC);
                  csr_wdata <= {epc_q[XLEN-1:1], 1'b0};
                  state     <= W_EPC;
               end else begin
                  drain_cnt <= drain_cnt + 4'd1;
               end
            end
            W_EPC: begin
               csr_we    <= 1'b1;
               csr_addr  <= csr_pick(to_s_q, MCAUSE, SCAUSE);
               csr_wdata <= cause_q;
               state     <= W_CAUSE;
            end
            W_CAUSE: begin
               csr_we    <= 1'b1;
               csr_addr  <= csr_pick(to_s_q, MTVAL, STVAL);
               csr_wdata <= tval_q;
               state     <= W_TVAL;
            end
            W_TVAL: begin
               status_commit <= 1'b1;
               commit_to_s   <= to_s_q;
               prev_priv     <= priv_q;
               state         <= COMMIT;
            end
            COMMIT: begin
               redirect_valid <= 1'b1;
               redirect_pc    <= vec_pc;
               state          <= REDIRECT;
            end
            REDIRECT: begin
               hold_pipe <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               hold_pipe <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_entry_seq.sv
// Self-checking bench for trap_entry_seq: directed table, corner sequences and
// randomized transactions against a timeline model.
module tb_trap_entry_seq;

   localparam int unsigned DMAX = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        int_req, int_target_s, exc_req, exc_to_s, pipe_idle;
   logic [63:0] int_cause, exc_cause, exc_tval, epc_in, mtvec, stvec;
   logic [3:0]  priv;
   logic        hold_pipe, trap_ack, csr_we, status_commit, commit_to_s;
   logic        redirect_valid, busy;
   logic [11:0] csr_addr;
   logic [63:0] csr_wdata, redirect_pc;
   logic [3:0]  prev_priv;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   trap_entry_seq #(.XLEN(64), .DRAIN_MAX(DMAX)) dut (
      .clk(clk), .rst(rst),
      .int_req(int_req), .int_target_s(int_target_s), .int_cause(int_cause),
      .exc_req(exc_req), .exc_to_s(exc_to_s), .exc_cause(exc_cause),
      .exc_tval(exc_tval), .epc_in(epc_in), .pipe_idle(pipe_idle),
      .mtvec(mtvec), .stvec(stvec), .priv(priv),
      .hold_pipe(hold_pipe), .trap_ack(trap_ack), .csr_we(csr_we),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .status_commit(status_commit), .commit_to_s(commit_to_s),
      .prev_priv(prev_priv), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .busy(busy)
   );

   typedef struct {
      logic        exc, intr, exc_s, int_s;
      logic [63:0] ecause, etval, icause, epc, mt, st;
      logic [3:0]  pv;
      int unsigned k;          // DRAIN cycle in which pipe_idle first rises
      int unsigned rst_at;     // 0: no reset, else cycle at which rst is raised
      logic        pulse_int;  // pulse int_req mid-DRAIN
      logic        exp_s;
      logic [63:0] exp_cause, exp_tval, exp_pc;
   } txn_t;

   task automatic chk(input string name, input int unsigned c,
                      input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
      end
   endtask

   // Reference from the trap rules, independent of the sequencer's states.
   function automatic txn_t model(input txn_t t);
      txn_t        r = t;
      logic [63:0] tv;
      r.exp_s     = t.exc ? t.exc_s : t.int_s;
      r.exp_cause = t.exc ? t.ecause : t.icause;
      r.exp_tval  = t.exc ? t.etval : 64'd0;
      tv          = r.exp_s ? t.st : t.mt;
      r.exp_pc    = (tv & ~64'd3);
      if (tv[1:0] == 2'b01 && r.exp_cause[63])
         r.exp_pc = r.exp_pc + 64'(r.exp_cause[5:0]) * 64'd4;
      return r;
   endfunction

   task automatic run_trap(input txn_t t);
      int unsigned d, last, wi;
      logic        live, e_we;
      logic [11:0] e_addr;
      logic [63:0] e_data;
      d    = (t.k < DMAX) ? t.k : DMAX;
      last = (t.rst_at != 0) ? t.rst_at + 3 : d + 6;
      @(negedge clk);
      exc_req = t.exc;   exc_to_s = t.exc_s; exc_cause = t.ecause; exc_tval = t.etval;
      int_req = t.intr;  int_target_s = t.int_s; int_cause = t.icause;
      epc_in = t.epc; mtvec = t.mt; stvec = t.st; priv = t.pv;
      pipe_idle = 1'($urandom_range(0, 1));
      for (int unsigned c = 1; c <= last; c++) begin
         @(negedge clk);
         live   = (t.rst_at == 0) || (c <= t.rst_at);
         e_we   = live && c >= d + 1 && c <= d + 3;
         e_addr = '0;
         e_data = '0;
         if (e_we) begin
            wi     = c - d - 1;
            e_addr = (t.exp_s ? 12'h141 : 12'h341) + 12'(wi);
            e_data = (wi == 0) ? (t.epc & ~64'd1) : (wi == 1) ? t.exp_cause : t.exp_tval;
         end
         chk("trap_ack", c, 64'(trap_ack), 64'(live && c == 1));
         chk("busy", c, 64'(busy), 64'(live && c <= d + 5));
         chk("hold_pipe", c, 64'(hold_pipe), 64'(live && c <= d + 5));
         chk("csr_we", c, 64'(csr_we), 64'(e_we));
         chk("csr_addr", c, 64'(csr_addr), 64'(e_addr));
         chk("csr_wdata", c, csr_wdata, e_data);
         chk("status_commit", c, 64'(status_commit), 64'(live && c == d + 4));
         chk("commit_to_s", c, 64'(commit_to_s), 64'(live && c == d + 4 && t.exp_s));
         chk("prev_priv", c, 64'(prev_priv), (live && c == d + 4) ? 64'(t.pv) : 64'd0);
         chk("redirect_valid", c, 64'(redirect_valid), 64'(live && c == d + 5));
         chk("redirect_pc", c, redirect_pc, (live && c == d + 5) ? t.exp_pc : 64'd0);
         if (c == 1) begin
            exc_req = 1'b0;
            int_req = 1'b0;
         end
         int_req   = t.pulse_int && (c == 2);
         pipe_idle = (c >= t.k);
         if (t.rst_at != 0 && c == t.rst_at) rst = 1'b1;
      end
      rst = 1'b0;
      int_req = 1'b0;
   endtask

   txn_t dir[6];
   txn_t t;

   initial begin
      rst = 1'b1;
      int_req = 0; int_target_s = 0; exc_req = 0; exc_to_s = 0; pipe_idle = 0;
      int_cause = '0; exc_cause = '0; exc_tval = '0; epc_in = '0;
      mtvec = '0; stvec = '0; priv = '0;

      // M interrupt, vectored: 0x8000_0000 + 11*4
      dir[0] = '{exc:0, intr:1, exc_s:0, int_s:0, ecause:0, etval:0,
                 icause:64'h8000_0000_0000_000B, epc:64'h1000_0004,
                 mt:64'h8000_0001, st:64'h0, pv:4'b1000, k:1, rst_at:0, pulse_int:0,
                 exp_s:0, exp_cause:64'h8000_0000_0000_000B, exp_tval:0,
                 exp_pc:64'h8000_002C};
      // Exception beats interrupt; vectored mode ignored for exceptions
      dir[1] = '{exc:1, intr:1, exc_s:0, int_s:1, ecause:64'd2, etval:64'hDEAD,
                 icause:64'h8000_0000_0000_0007, epc:64'h2003,
                 mt:64'h8000_0101, st:64'h7000, pv:4'b0001, k:2, rst_at:0, pulse_int:0,
                 exp_s:0, exp_cause:64'd2, exp_tval:64'hDEAD, exp_pc:64'h8000_0100};
      // S-delegated exception, direct stvec
      dir[2] = '{exc:1, intr:0, exc_s:1, int_s:0, ecause:64'd5, etval:64'h1234,
                 icause:0, epc:64'h3000, mt:64'h9000, st:64'h4000,
                 pv:4'b0010, k:1, rst_at:0, pulse_int:0,
                 exp_s:1, exp_cause:64'd5, exp_tval:64'h1234, exp_pc:64'h4000};
      // Drain timeout, then pipe_idle at DRAIN cycle 3
      dir[3] = '{exc:1, intr:0, exc_s:0, int_s:0, ecause:64'd7, etval:64'h55,
                 icause:0, epc:64'h4444, mt:64'h100, st:64'h0,
                 pv:4'b1000, k:20, rst_at:0, pulse_int:0,
                 exp_s:0, exp_cause:64'd7, exp_tval:64'h55, exp_pc:64'h100};
      dir[4] = dir[3];
      dir[4].k = 3;
      // S interrupt, vectored target wraps past 2^64
      dir[5] = '{exc:0, intr:1, exc_s:0, int_s:1, ecause:0, etval:0,
                 icause:64'h8000_0000_0000_0009, epc:64'h5000,
                 mt:64'h0, st:64'hFFFF_FFFF_FFFF_FFFD, pv:4'b0001, k:1, rst_at:0,
                 pulse_int:0, exp_s:1, exp_cause:64'h8000_0000_0000_0009, exp_tval:0,
                 exp_pc:64'h20};

      repeat (3) @(negedge clk);
      chk("rst_busy", 0, 64'(busy), 64'd0);
      chk("rst_hold", 0, 64'(hold_pipe), 64'd0);
      chk("rst_ack", 0, 64'(trap_ack), 64'd0);
      chk("rst_we", 0, 64'(csr_we), 64'd0);
      chk("rst_redir", 0, 64'(redirect_valid), 64'd0);
      chk("rst_pc", 0, redirect_pc, 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_trap(dir[i]);

      // Reset raised while W_CAUSE is current (k=1 -> W_CAUSE at cycle 3)
      t = dir[0];
      t.rst_at = 3;
      run_trap(t);
      run_trap(dir[2]);

      // int_req pulsed during DRAIN must be ignored
      t = dir[2];
      t.k = 6;
      t.pulse_int = 1'b1;
      t.icause = 64'h8000_0000_0000_0003;
      run_trap(t);

      for (int i = 0; i < 30; i++) begin
         t.exc       = 1'($urandom_range(0, 1));
         t.intr      = t.exc ? 1'($urandom_range(0, 1)) : 1'b1;
         t.exc_s     = 1'($urandom_range(0, 1));
         t.int_s     = 1'($urandom_range(0, 1));
         t.ecause    = 64'($urandom_range(0, 15));
         t.etval     = {$urandom, $urandom};
         t.icause    = {1'b1, 31'($urandom), $urandom};
         t.epc       = {$urandom, $urandom};
         t.mt        = {$urandom, $urandom};
         t.st        = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) t.mt[1:0] = 2'b01;
         if ($urandom_range(0, 1) == 1) t.st[1:0] = 2'b01;
         case ($urandom_range(0, 2))
            0:       t.pv = 4'b0001;
            1:       t.pv = 4'b0010;
            default: t.pv = 4'b1000;
         endcase
         t.k         = $urandom_range(1, 18);
         t.rst_at    = 0;
         t.pulse_int = 1'($urandom_range(0, 1));
         t = model(t);
         run_trap(t);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
